// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller between the execute stage and a
// word-organised data memory. One request at a time, word-aligned memory
// accesses, read-modify-write for byte/halfword stores, and sign/zero
// extension of loads. Exactly one response is returned per accepted request.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned halfword/word accesses are rejected with rsp_err
//   undefined -> misaligned halfwords use lane addr[1], words ignore addr[1:0]

module lsu_mem_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] DMEM_BASE  = 'h0200_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW,
        STORE,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] merged_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  req_err;
    logic                  accept;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merge_data;

    assign accept = (state == IDLE) && req_valid;

    // Classify the incoming request as illegal (range, size code, alignment)
    always_comb begin
        req_err = 1'b0;
        if (req_addr < DMEM_BASE) begin
            req_err = 1'b1;
        end
        case (req_funct3)
            3'b011, 3'b110, 3'b111: req_err = 1'b1;
            3'b100, 3'b101: begin
                if (req_we) begin
                    req_err = 1'b1;
                end
            end
            default: ;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
            req_err = 1'b1;
        end
        if ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
`endif
    end

    // Pick the addressed lane out of the memory word and extend it
    always_comb begin
        byte_sel  = mem_rd_data[{addr_q[1:0], 3'b000} +: 8];
        half_sel  = mem_rd_data[{addr_q[1], 4'b0000} +: 16];
        load_data = mem_rd_data;
        case (funct3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_data = mem_rd_data;
        endcase
    end

    // Merge the store byte/halfword into the old memory word
    always_comb begin
        merge_data = mem_rd_data;
        if (funct3_q[1:0] == 2'b00) begin
            merge_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_data[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        next_state = RESP;
                    end else if (!req_we) begin
                        next_state = LOAD;
                    end else if (req_funct3[1:0] == 2'b10) begin
                        next_state = STORE;
                    end else begin
                        next_state = RMW;
                    end
                end
            end
            LOAD:    next_state = RESP;
            RMW:     next_state = STORE;
            STORE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the request and register load result / merged store word
    always_ff @(posedge clk) begin
        if (reset) begin
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
                rdata_q  <= '0;
            end
            if (state == LOAD) begin
                rdata_q <= load_data;
            end
            if (state == RMW) begin
                merged_q <= merge_data;
            end
        end
    end

    // Drive handshake, response and memory port from the current state
    always_comb begin
        req_ready   = (state == IDLE);
        rsp_valid   = (state == RESP);
        rsp_err     = (state == RESP) && err_q;
        rsp_rdata   = (state == RESP) ? rdata_q : '0;
        mem_wr_en   = (state == STORE);
        mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_wr_data = '0;
        if (state == STORE) begin
            mem_wr_data = (funct3_q[1:0] == 2'b10) ? wdata_q : merged_q;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: randomized bench for lsu_mem_ctrl with a behavioural
// model of the load/store rules and a small word memory attached to the port.

module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    lsu_mem_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    // Memory word content at start of simulation, shared by memory and model
    function automatic logic [31:0] initWord(input int i);
        return (32'h9E37_79B9 * (i + 1)) ^ 32'h5A5A_0F0F;
    endfunction

    // Attached data memory: 16 words, aliased on address bits [5:2]
    logic [31:0] mem [16];
    bit          mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= initWord(i);
            mem_loaded <= 1'b1;
        end else if (mem_wr_en) begin
            mem[mem_addr[5:2]] <= mem_wr_data;
        end
    end
    assign mem_rd_data = mem[mem_addr[5:2]];

    // Cycle counter
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectation state shared between driver and compare process
    logic [31:0] ref_mem [16];
    bit          busy = 1'b0;
    bit          cmp_en = 1'b0;
    int          acc = 0;
    int          exp_lat = 0;
    int          exp_wrk = -1;
    bit          exp_err = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] exp_waddr = '0;
    bit          lit_en = 1'b0;
    logic [31:0] lit_data = '0;
    bit          lit_err = 1'b0;

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: latency, error, load result and new memory word
    function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] word,
                                  output int lat, output int wrk, output bit err,
                                  output logic [31:0] rd, output logic [31:0] nw);
        int          sh;
        logic [31:0] mask;
        err = (a < 32'h0200_0000) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7)
              || (we && ((f3 == 3'd4) || (f3 == 3'd5)));
`ifdef LSU_MISALIGN_TRAP_EN
        if (((f3 == 3'd1) || (f3 == 3'd5)) && a[0]) err = 1'b1;
        if ((f3 == 3'd2) && (a[1:0] != 2'b00)) err = 1'b1;
`endif
        rd  = '0;
        nw  = word;
        wrk = -1;
        lat = 0;
        if (err) begin
            lat = 0;
        end else if (!we) begin
            lat = 1;
            if ((f3 == 3'd0) || (f3 == 3'd4)) begin
                sh = 8 * int'(a[1:0]);
                rd = (word >> sh) & 32'hFF;
                if ((f3 == 3'd0) && rd[7]) rd = rd | 32'hFFFF_FF00;
            end else if ((f3 == 3'd1) || (f3 == 3'd5)) begin
                sh = 16 * int'(a[1]);
                rd = (word >> sh) & 32'hFFFF;
                if ((f3 == 3'd1) && rd[15]) rd = rd | 32'hFFFF_0000;
            end else begin
                rd = word;
            end
        end else if (f3 == 3'd2) begin
            lat = 1;
            wrk = 0;
            nw  = wd;
        end else begin
            lat  = 2;
            wrk  = 1;
            sh   = (f3 == 3'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
            mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
            nw   = (word & ~mask) | ((wd << sh) & mask);
        end
    endfunction

    // Compare process: checks every output against the model each cycle
    always @(negedge clk) begin
        int  k;
        bit  rsp_exp;
        bit  wr_exp;
        bit  idle_exp;
        if (cmp_en) begin
            k        = cyc - acc;
            rsp_exp  = busy && (k == exp_lat);
            wr_exp   = busy && (k == exp_wrk);
            idle_exp = !busy || (k > exp_lat);
            checkOutput("req_ready", {31'd0, req_ready}, {31'd0, idle_exp});
            checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, rsp_exp});
            checkOutput("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, wr_exp});
            checkOutput("mem_wr_data", mem_wr_data, wr_exp ? exp_wdata : 32'h0);
            if (busy && (k <= exp_lat)) begin
                checkOutput("mem_addr", mem_addr, exp_waddr);
            end
            if (rsp_exp) begin
                checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
                checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
                if (lit_en) begin
                    checkOutput("lit_rdata", rsp_rdata, lit_data);
                    checkOutput("lit_err", {31'd0, rsp_err}, {31'd0, lit_err});
                end
            end
            if (reset && !busy) begin
                checkOutput("reset_mem_addr", mem_addr, 32'h0);
                checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
                checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'h0);
            end
        end
    end

    // Issue one request, optionally aborting it with reset one cycle in
    task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input bit abort,
                                 input bit len, input logic [31:0] ld, input bit le);
        int          lat;
        int          wrk;
        bit          err;
        logic [31:0] rd;
        logic [31:0] nw;
        bit          hold;
        model(we, f3, a, wd, ref_mem[a[5:2]], lat, wrk, err, rd, nw);
        @(negedge clk); #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk); #1;
        acc       = cyc;
        exp_lat   = lat;
        exp_wrk   = wrk;
        exp_err   = err;
        exp_rdata = rd;
        exp_wdata = nw;
        exp_waddr = {a[31:2], 2'b00};
        lit_en    = len;
        lit_data  = ld;
        lit_err   = le;
        busy      = 1'b1;
        hold      = 1'($urandom % 2);
        req_valid = hold;
        if (hold) begin
            req_we     = 1'($urandom % 2);
            req_funct3 = 3'($urandom % 8);
            req_addr   = 32'h0200_0000 + ($urandom % 64);
            req_wdata  = $urandom;
        end
        if (abort) begin
            @(negedge clk); #1;
            reset     = 1'b1;
            req_valid = 1'b0;
            @(posedge clk); #1;
            busy = 1'b0;
            @(negedge clk); #1;
            reset = 1'b0;
        end else begin
            repeat (lat + 1) @(posedge clk);
            #1;
            req_valid = 1'b0;
            busy      = 1'b0;
            if (wrk >= 0) ref_mem[a[5:2]] = nw;
        end
    endtask

    initial begin
        bit          rwe;
        logic [2:0]  rf3;
        logic [31:0] raddr;
        for (int i = 0; i < 16; i++) ref_mem[i] = initWord(i);
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;

        $display("[TB] directed sequence");
        applyStimulus(1'b1, 3'b010, 32'h0200_0000, 32'h1122_3344, 1'b0, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b1, 3'b010, 32'h0200_0004, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, 3'b000, 32'h0200_0007, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFDE, 1'b0);
        applyStimulus(1'b0, 3'b100, 32'h0200_0006, 32'h0, 1'b0, 1'b1, 32'h0000_00AD, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h0200_0004, 32'h0, 1'b0, 1'b1, 32'hFFFF_BEEF, 1'b0);
        applyStimulus(1'b0, 3'b101, 32'h0200_0006, 32'h0, 1'b0, 1'b1, 32'h0000_DEAD, 1'b0);
        applyStimulus(1'b1, 3'b000, 32'h0200_0005, 32'h1234_5677, 1'b0, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h0200_0004, 32'h0, 1'b0, 1'b1, 32'hDEAD_77EF, 1'b0);
        applyStimulus(1'b1, 3'b001, 32'h0200_0006, 32'h0000_CAFE, 1'b0, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h0200_0004, 32'h0, 1'b0, 1'b1, 32'hCAFE_77EF, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h0000_1000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b011, 32'h0200_0000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        applyStimulus(1'b1, 3'b100, 32'h0200_0008, 32'h55, 1'b0, 1'b1, 32'h0, 1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 3'b010, 32'h0200_0002, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b001, 32'h0200_0005, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
`else
        applyStimulus(1'b0, 3'b010, 32'h0200_0002, 32'h0, 1'b0, 1'b1, 32'h1122_3344, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h0200_0005, 32'h0, 1'b0, 1'b1, 32'h0000_77EF, 1'b0);
`endif
        applyStimulus(1'b1, 3'b000, 32'h0200_0004, 32'h0000_0055, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h0200_0004, 32'h0, 1'b0, 1'b1, 32'hCAFE_77EF, 1'b0);

        $display("[TB] random sequence");
        for (int n = 0; n < 250; n++) begin
            rwe   = 1'($urandom % 2);
            rf3   = 3'($urandom % 8);
            raddr = (($urandom % 8) == 0) ? 32'h01FF_FFC0 + ($urandom % 64)
                                          : 32'h0200_0000 + ($urandom % 64);
            applyStimulus(rwe, rf3, raddr, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
